// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack handshake to instruction memory, one-slot output to decode.
// Optional FETCH_STATS_EN adds fetch_count / stall_count performance counters.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     stall_count
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDiscard} state_e;

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;
  logic [31:0]     instr_q, instr_d;

  logic slot_free;
  logic consume;
  logic ack;
  logic unused_redirect_lsb;

  assign slot_free = !valid_q || !stall;
  assign consume   = valid_q && !stall && !redirect;
  assign ack       = imem_ack && (state_q != StIdle);

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    valid_d     = valid_q;
    slot_pc_d   = slot_pc_q;
    instr_d     = instr_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!redirect && slot_free) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (redirect) begin
          // Keep the in-flight address on the bus until memory answers.
          state_d     = ack ? StIdle : StDiscard;
          hold_addr_d = pc_q;
        end else if (ack) begin
          instr_d   = imem_rdata;
          slot_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + PcStep;
          state_d   = StIdle;
        end
      end
      StDiscard: begin
        if (ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      hold_addr_q <= '0;
      valid_q     <= 1'b0;
      slot_pc_q   <= '0;
      instr_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      valid_q     <= valid_d;
      slot_pc_q   <= slot_pc_d;
      instr_q     <= instr_d;
    end
  end

  assign imem_req  = (state_q != StIdle);
  assign imem_addr = (state_q == StDiscard) ? hold_addr_q : pc_q;
  assign if_valid  = valid_q;
  assign if_pc     = slot_pc_q;
  assign if_instr  = instr_q;
  assign if_opcode = instr_q[6:0];

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (consume) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (valid_q && stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
